mul_seq_ctrl: RTL

Sequencing controller for the repeated-addition multiplier datapath: register A (multiplicand), down-counter B (multiplier), accumulator P with adder, and zero-compare `eq` on B. It accepts an operand pair through a start/done handshake and drives the datapath's shared `datain` bus and all load, clear and decrement strobes. It keeps a shadow iteration count and cross-checks it against the datapath's `eq`. The product is read from the datapath accumulator output while `done` is high.

---
 rtl/mul_seq_ctrl_if.sv | 37 +++
 rtl/mul_seq_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Handshake and datapath bus for the repeated-addition multiplier controller.
//   start/abort/opa/opb : request side, driven toward the controller
//   eq                  : datapath B==0 flag, driven toward the controller
//   datain              : shared operand bus to datapath registers A and B
//   lda/ldb/ldp         : load A, load B, accumulate P <= P + A
//   clra/clrp/decb      : clear A, clear P, decrement B
//   busy/done/err       : controller status
// The master modport is the requester/datapath side; the controller uses slave.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             eq;
  logic [WIDTH-1:0] datain;
  logic             lda;
  logic             ldb;
  logic             ldp;
  logic             clra;
  logic             clrp;
  logic             decb;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, opa, opb, eq,
    input  datain, lda, ldb, ldp, clra, clrp, decb, busy, done, err
  );

  modport slave (
    input  start, abort, opa, opb, eq,
    output datain, lda, ldb, ldp, clra, clrp, decb, busy, done, err
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a repeated-addition multiplier datapath
// (A = multiplicand register, B = down-counting multiplier, P = accumulator).
// Accepts an operand pair on start, loads A and B over the shared datain bus,
// pulses ldp/decb once per multiplier unit, and signals done for one cycle.
// A shadow count rem tracks the expected iterations; when the sequence ends
// the datapath's eq flag must agree, otherwise the sticky err flag is set.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mul_seq_ctrl_if.slave (handshake, operands, strobes, status)
// Parameters:
//   WIDTH    : operand width
//   SWAP_MIN : 1 loads the smaller operand into B to minimise iterations
module mul_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit SWAP_MIN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_CHECK,
    S_ADD,
    S_DONE,
    S_CLEAR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem;
  logic             err_q;
  logic             accept;
  logic             abort_now;

  // Returns {mcand, mplier}. Ties keep opa as the multiplicand.
  function automatic logic [2*WIDTH-1:0] order_ops(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    if (SWAP_MIN && (a < b)) begin
      return {b, a};
    end
    return {a, b};
  endfunction

  assign accept    = (state == S_IDLE) && bus.start;
  // Abort only matters once an operation is underway; CLEAR already unwinds.
  assign abort_now = bus.abort && (state != S_IDLE) && (state != S_CLEAR);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, shadow counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      {mcand, mplier} <= order_ops(bus.opa, bus.opb);
      err_q           <= 1'b0;
    end else if (!abort_now) begin
      case (state)
        S_LOADB: rem <= mplier;
        S_ADD:   rem <= rem - WIDTH'(1);
        S_DONE:  if (!bus.eq) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_LOADA;
      S_LOADA: state_next = S_LOADB;
      S_LOADB: state_next = S_CHECK;
      S_CHECK: state_next = (rem == '0) ? S_DONE : S_ADD;
      // rem still holds the pre-decrement value, so 1 means this is the last add.
      S_ADD:   state_next = (rem == WIDTH'(1)) ? S_DONE : S_ADD;
      S_DONE:  state_next = S_IDLE;
      S_CLEAR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_now) begin
      state_next = S_CLEAR;
    end
  end

  // Output decode; an abort cycle keeps every strobe and the bus quiet.
  always_comb begin
    bus.datain = '0;
    bus.lda    = 1'b0;
    bus.ldb    = 1'b0;
    bus.ldp    = 1'b0;
    bus.clra   = 1'b0;
    bus.clrp   = 1'b0;
    bus.decb   = 1'b0;
    bus.done   = 1'b0;
    if (!abort_now) begin
      case (state)
        S_LOADA: begin
          bus.datain = mcand;
          bus.lda    = 1'b1;
          bus.clrp   = 1'b1;
        end
        S_LOADB: begin
          bus.datain = mplier;
          bus.ldb    = 1'b1;
        end
        S_ADD: begin
          bus.ldp  = 1'b1;
          bus.decb = 1'b1;
        end
        S_DONE:  bus.done = 1'b1;
        S_CLEAR: begin
          bus.clra = 1'b1;
          bus.clrp = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.err  = err_q;

endmodule
